// File: rtl/csr_regfile_if.sv
// csr_regfile_if: EX-stage Zicsr access port plus the trap-controller (CLINT) write port.
//   ex_csr_addr/we/op/src : EX read/write request, ex_csr_rdata/ex_csr_illegal : combinational response
//   clint_we/wa/wd        : trap-controller raw write port
interface csr_regfile_if;
    logic [11:0] ex_csr_addr;
    logic        ex_csr_we;
    logic [1:0]  ex_csr_op;
    logic [31:0] ex_csr_src;
    logic [31:0] ex_csr_rdata;
    logic        ex_csr_illegal;
    logic        clint_we;
    logic [11:0] clint_wa;
    logic [31:0] clint_wd;
    modport master (
        output ex_csr_addr, ex_csr_we, ex_csr_op, ex_csr_src, clint_we, clint_wa, clint_wd,
        input  ex_csr_rdata, ex_csr_illegal
    );
    modport slave (
        input  ex_csr_addr, ex_csr_we, ex_csr_op, ex_csr_src, clint_we, clint_wa, clint_wd,
        output ex_csr_rdata, ex_csr_illegal
    );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR file with EX Zicsr access, trap-controller write port and 64-bit counters.
//   clk, rst                 : clock, asynchronous active-high reset
//   bus (slave)              : EX access and CLINT write port
//   interrupt_flag           : raw interrupt sources mirrored into mip
//   instr_retire             : one instruction retired this cycle
//   csr_mtvec/mepc/mstatus   : registered CSR values for the trap controller
//   interrupt_enable         : mstatus.MIE
module csr_regfile #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] HARTID    = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    csr_regfile_if.slave      bus,
    input  logic [7:0]        interrupt_flag,
    input  logic              instr_retire,
    output logic [31:0]       csr_mtvec,
    output logic [31:0]       csr_mepc,
    output logic [31:0]       csr_mstatus,
    output logic              interrupt_enable
);
    logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [31:0] raw, ex_wd;
    logic        hit, ex_wr;
    logic [11:0] ca, ea;
    logic [32:0] w_ms, w_mie, w_tv, w_sc, w_ep, w_mc, w_cl, w_ch, w_il, w_ih;

    // Idle ports present address 0, which matches no CSR; CLINT takes priority on a collision.
    function automatic logic [32:0] wsel(input logic [11:0] a, input logic [11:0] c, input logic [11:0] e,
                                         input logic [31:0] cd, input logic [31:0] ed);
        wsel = (c == a) ? {1'b1, cd} : (e == a) ? {1'b1, ed} : 33'd0;
    endfunction

    always_comb begin
        raw = '0;
        hit = 1'b1;
        case (bus.ex_csr_addr)
            12'h300: raw = mstatus_q | 32'h0000_1800;
            12'h304: raw = mie_q;
            12'h305: raw = mtvec_q;
            12'h340: raw = mscratch_q;
            12'h341: raw = mepc_q;
            12'h342: raw = mcause_q;
            12'h344: raw = {24'd0, interrupt_flag};
            12'hB00, 12'hC00: raw = mcycle_q[31:0];
            12'hB80, 12'hC80: raw = mcycle_q[63:32];
            12'hB02, 12'hC02: raw = minstret_q[31:0];
            12'hB82, 12'hC82: raw = minstret_q[63:32];
            12'hF14: raw = HARTID;
            default: hit = 1'b0;
        endcase
    end

    assign bus.ex_csr_illegal = !hit || (bus.ex_csr_we && bus.ex_csr_addr[11:10] == 2'b11);
    assign bus.ex_csr_rdata   = bus.ex_csr_illegal ? 32'd0 : raw;
    assign ex_wr = bus.ex_csr_we && bus.ex_csr_op != 2'b00 && !bus.ex_csr_illegal;
    assign ex_wd = bus.ex_csr_op == 2'b01 ? bus.ex_csr_src :
                   bus.ex_csr_op == 2'b10 ? raw | bus.ex_csr_src : raw & ~bus.ex_csr_src;
    assign ca = bus.clint_we ? bus.clint_wa : 12'h000;
    assign ea = ex_wr ? bus.ex_csr_addr : 12'h000;

    assign w_ms  = wsel(12'h300, ca, ea, bus.clint_wd, ex_wd);
    assign w_mie = wsel(12'h304, ca, ea, bus.clint_wd, ex_wd);
    assign w_tv  = wsel(12'h305, ca, ea, bus.clint_wd, ex_wd);
    assign w_sc  = wsel(12'h340, ca, ea, bus.clint_wd, ex_wd);
    assign w_ep  = wsel(12'h341, ca, ea, bus.clint_wd, ex_wd);
    assign w_mc  = wsel(12'h342, ca, ea, bus.clint_wd, ex_wd);
    assign w_cl  = wsel(12'hB00, ca, ea, bus.clint_wd, ex_wd);
    assign w_ch  = wsel(12'hB80, ca, ea, bus.clint_wd, ex_wd);
    assign w_il  = wsel(12'hB02, ca, ea, bus.clint_wd, ex_wd);
    assign w_ih  = wsel(12'hB82, ca, ea, bus.clint_wd, ex_wd);

    always_comb begin
        mstatus_d  = w_ms[32]  ? w_ms[31:0] & 32'h0000_0088 : mstatus_q;
        mie_d      = w_mie[32] ? w_mie[31:0] & 32'h0000_00FF : mie_q;
        mtvec_d    = w_tv[32]  ? w_tv[31:0] & ~32'd3 : mtvec_q;
        mscratch_d = w_sc[32]  ? w_sc[31:0] : mscratch_q;
        mepc_d     = w_ep[32]  ? w_ep[31:0] & ~32'd3 : mepc_q;
        mcause_d   = w_mc[32]  ? w_mc[31:0] : mcause_q;
        // A write to either half suppresses that counter's increment for the cycle.
        mcycle_d   = (w_cl[32] || w_ch[32]) ?
                     {w_ch[32] ? w_ch[31:0] : mcycle_q[63:32], w_cl[32] ? w_cl[31:0] : mcycle_q[31:0]} :
                     mcycle_q + 64'd1;
        minstret_d = (w_il[32] || w_ih[32]) ?
                     {w_ih[32] ? w_ih[31:0] : minstret_q[63:32], w_il[32] ? w_il[31:0] : minstret_q[31:0]} :
                     minstret_q + {63'd0, instr_retire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= {MTVEC_RST[31:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign csr_mtvec        = mtvec_q;
    assign csr_mepc         = mepc_q;
    assign csr_mstatus      = mstatus_q | 32'h0000_1800;
    assign interrupt_enable = mstatus_q[3];
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed scoreboard bench for csr_regfile.
module tb_csr_regfile;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
    localparam logic [31:0] HARTID    = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  interrupt_flag;
    logic        instr_retire;
    logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
    logic        interrupt_enable;
    logic [31:0] old_val;
    int          checks = 0;
    int          failures = 0;
    string       exp_tag[$];
    logic [31:0] exp_val[$];

    csr_regfile_if bus();

    csr_regfile #(.MTVEC_RST(MTVEC_RST), .HARTID(HARTID)) dut (
        .clk(clk), .rst(rst), .bus(bus), .interrupt_flag(interrupt_flag), .instr_retire(instr_retire),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
        .interrupt_enable(interrupt_enable)
    );

    always #5 clk = ~clk;

    task automatic sb_push(input string t, input logic [31:0] v);
        exp_tag.push_back(t);
        exp_val.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_val.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            t = exp_tag.pop_front();
            e = exp_val.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s obs=%h exp=%h", t, obs, e);
            end
        end
    endtask

    task automatic rd(input logic [11:0] a, input string t, input logic [31:0] e);
        @(negedge clk);
        bus.ex_csr_addr = a;
        bus.ex_csr_we = 1'b0;
        bus.ex_csr_op = 2'b00;
        sb_push(t, e);
        #1 sb_pop(bus.ex_csr_rdata);
    endtask

    task automatic ex_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] src);
        @(negedge clk);
        bus.ex_csr_addr = a;
        bus.ex_csr_we = 1'b1;
        bus.ex_csr_op = op;
        bus.ex_csr_src = src;
        #1 old_val = bus.ex_csr_rdata;
        @(negedge clk);
        bus.ex_csr_we = 1'b0;
        bus.ex_csr_op = 2'b00;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        interrupt_flag = 8'h00;
        instr_retire = 1'b0;
        bus.ex_csr_addr = 12'h000;
        bus.ex_csr_we = 1'b0;
        bus.ex_csr_op = 2'b00;
        bus.ex_csr_src = 32'd0;
        bus.clint_we = 1'b0;
        bus.clint_wa = 12'h000;
        bus.clint_wd = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // reset state
        rd(12'h300, "rst_mstatus", 32'h0000_1800);
        rd(12'h305, "rst_mtvec", 32'h0000_1000);
        sb_push("rst_ie", 32'd0);
        sb_pop({31'd0, interrupt_enable});
        rd(12'h341, "rst_mepc", 32'd0);
        rd(12'hF14, "mhartid", HARTID);
        rd(12'h7C0, "bad_rdata", 32'd0);
        sb_push("bad_illegal", 32'd1);
        sb_pop({31'd0, bus.ex_csr_illegal});
        // mstatus RW then RC
        ex_write(12'h300, 2'b01, 32'hFFFF_FFFF);
        sb_push("mstatus_rw", 32'h0000_1888);
        sb_pop(csr_mstatus);
        sb_push("ie_set", 32'd1);
        sb_pop({31'd0, interrupt_enable});
        ex_write(12'h300, 2'b11, 32'h0000_0008);
        sb_push("mstatus_rc", 32'h0000_1880);
        sb_pop(csr_mstatus);
        sb_push("ie_clr", 32'd0);
        sb_pop({31'd0, interrupt_enable});
        // mtvec, mscratch RS, mie, mcause
        ex_write(12'h305, 2'b01, 32'h8000_0103);
        rd(12'h305, "mtvec_rd", 32'h8000_0100);
        sb_push("mtvec_out", 32'h8000_0100);
        sb_pop(csr_mtvec);
        ex_write(12'h340, 2'b01, 32'd3);
        ex_write(12'h340, 2'b10, 32'd5);
        sb_push("rs_old_value", 32'd3);
        sb_pop(old_val);
        rd(12'h340, "mscratch_rs", 32'd7);
        ex_write(12'h304, 2'b01, 32'hFFFF_FFFF);
        rd(12'h304, "mie_mask", 32'h0000_00FF);
        ex_write(12'h342, 2'b01, 32'hDEAD_BEEF);
        rd(12'h342, "mcause", 32'hDEAD_BEEF);
        // read-only write is illegal and changes nothing
        @(negedge clk);
        bus.ex_csr_addr = 12'hF14;
        bus.ex_csr_we = 1'b1;
        bus.ex_csr_op = 2'b01;
        bus.ex_csr_src = 32'h1234;
        sb_push("ro_illegal", 32'd1);
        #1 sb_pop({31'd0, bus.ex_csr_illegal});
        rd(12'hF14, "ro_unchanged", HARTID);
        // CLINT vs EX collision, then independent writes
        @(negedge clk);
        bus.clint_we = 1'b1;
        bus.clint_wa = 12'h341;
        bus.clint_wd = 32'h100;
        bus.ex_csr_addr = 12'h341;
        bus.ex_csr_we = 1'b1;
        bus.ex_csr_op = 2'b01;
        bus.ex_csr_src = 32'h200;
        @(negedge clk);
        bus.ex_csr_addr = 12'h340;
        bus.ex_csr_src = 32'hABC;
        bus.clint_wd = 32'h47;
        sb_push("clint_wins", 32'h100);
        #1 sb_pop(csr_mepc);
        @(negedge clk);
        bus.clint_we = 1'b0;
        bus.clint_wa = 12'h000;
        bus.ex_csr_we = 1'b0;
        bus.ex_csr_op = 2'b00;
        sb_push("clint_mepc", 32'h44);
        #1 sb_pop(csr_mepc);
        rd(12'h340, "ex_mscratch", 32'hABC);
        // mcycle carry and read-only alias
        ex_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
        rd(12'hC00, "cycle_lo_wrap", 32'd0);
        rd(12'hC80, "cycle_hi_carry", 32'd1);
        @(negedge clk);
        bus.ex_csr_addr = 12'hC00;
        bus.ex_csr_we = 1'b1;
        bus.ex_csr_op = 2'b01;
        bus.ex_csr_src = 32'd0;
        sb_push("cycle_wr_illegal", 32'd1);
        #1 sb_pop({31'd0, bus.ex_csr_illegal});
        rd(12'hC00, "cycle_unaffected", 32'd3);
        // minstret
        ex_write(12'hB02, 2'b01, 32'd5);
        @(negedge clk);
        instr_retire = 1'b1;
        repeat (3) @(negedge clk);
        instr_retire = 1'b0;
        rd(12'hC02, "instret_count", 32'd8);
        ex_write(12'hB82, 2'b01, 32'd7);
        rd(12'hB82, "minstreth", 32'd7);
        // async reset during an EX write
        interrupt_flag = 8'h01;
        @(negedge clk);
        bus.ex_csr_addr = 12'h340;
        bus.ex_csr_we = 1'b1;
        bus.ex_csr_op = 2'b01;
        bus.ex_csr_src = 32'h123;
        #2 rst = 1'b1;
        #1;
        sb_push("mid_rst_mstatus", 32'h0000_1800);
        sb_pop(csr_mstatus);
        sb_push("mid_rst_mtvec", 32'h0000_1000);
        sb_pop(csr_mtvec);
        sb_push("mid_rst_mepc", 32'd0);
        sb_pop(csr_mepc);
        @(negedge clk);
        rst = 1'b0;
        bus.ex_csr_we = 1'b0;
        bus.ex_csr_op = 2'b00;
        rd(12'h340, "rst_mscratch", 32'd0);
        rd(12'hB82, "rst_minstreth", 32'd0);
        rd(12'h344, "mip_rd", 32'd1);
        @(negedge clk);
        bus.ex_csr_addr = 12'h344;
        bus.ex_csr_we = 1'b1;
        bus.ex_csr_op = 2'b01;
        bus.ex_csr_src = 32'hFF;
        sb_push("mip_wr_legal", 32'd0);
        #1 sb_pop({31'd0, bus.ex_csr_illegal});
        rd(12'h344, "mip_unchanged", 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
